status_led_bank: RTL and testbench

- Parametrised bank of N_CHAN status-LED channels, driven from the board clock domain. Generalises the single fixed heartbeat toggler.
- Each channel runs in one of four modes: OFF, ON, BLINK, STRETCH.
- BLINK uses a shared, phase-locked blink timebase. STRETCH turns one-cycle events into visible pulses.
- A global PWM brightness control gates all outputs. The block drives board LEDs (ledr) directly.

---
 rtl/status_led_bank.sv | 158 +++++++++++++++
 tb/tb_status_led_bank.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/status_led_bank.sv
// ---------------------------------------------------------------------------
// status_led_bank
//
// Bank of N_CHAN status-LED channels running from the board clock. Each
// channel selects one of four modes: OFF, ON, BLINK (shared, free-running
// blink timebase so every blinking LED stays in phase) or STRETCH (a one-cycle
// event becomes a pulse of STRETCH_MS ticks). A global PWM duty control gates
// every output.
//
// Ports:
//   clk_33     in   sole clock
//   rst        in   synchronous reset, active-high
//   mode       in   2*N_CHAN bits; mode[2i+1:2i] for channel i:
//                   0 OFF, 1 ON, 2 BLINK, 3 STRETCH
//   event_in   in   N_CHAN per-channel event strobes, sampled every cycle
//   brightness in   PWM_BITS global duty: 0 = dark, all-ones = full
//   tick_ms    out  one-cycle strobe every TICK_DIV cycles (registered)
//   led        out  N_CHAN registered LED outputs
// ---------------------------------------------------------------------------
module status_led_bank #(
  parameter int N_CHAN        = 10,
  parameter int TICK_DIV      = 33000,
  parameter int BLINK_HALF_MS = 1000,
  parameter int STRETCH_MS    = 50,
  parameter int PWM_BITS      = 4
) (
  input  logic                  clk_33,
  input  logic                  rst,
  input  logic [2*N_CHAN-1:0]   mode,
  input  logic [N_CHAN-1:0]     event_in,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic                  tick_ms,
  output logic [N_CHAN-1:0]     led
);

  localparam int DIV_W = $clog2(TICK_DIV);
  // A one-tick half-period still needs a 1-bit counter to stay legal.
  localparam int MS_W  = (BLINK_HALF_MS > 1) ? $clog2(BLINK_HALF_MS) : 1;
  localparam int S_W   = $clog2(STRETCH_MS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(BLINK_HALF_MS - 1);
  localparam logic [S_W-1:0]   S_LOAD   = S_W'(STRETCH_MS);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_STRETCH = 2'd3;

  // Shared timing state
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                tick;
  logic                tick_ms_q, tick_ms_d;
  logic [MS_W-1:0]     ms_cnt_q, ms_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_on;

  // Per-channel level before PWM gating, and the output register
  logic [N_CHAN-1:0]   raw;
  logic [N_CHAN-1:0]   led_q, led_d;

  // -------------------------------------------------------------------------
  // Prescaler, blink timebase and PWM counter
  // -------------------------------------------------------------------------
  always_comb begin
    tick          = (div_cnt_q == DIV_LAST);
    div_cnt_d     = tick ? '0 : div_cnt_q + DIV_W'(1);
    tick_ms_d     = tick;

    ms_cnt_d      = ms_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick) begin
      if (ms_cnt_q == MS_LAST) begin
        ms_cnt_d      = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        ms_cnt_d      = ms_cnt_q + MS_W'(1);
      end
    end

    pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
    // All-ones brightness must be truly full-on; a plain compare would
    // leave one dark slot per PWM period.
    pwm_on        = (&brightness) | (pwm_cnt_q < brightness);

    led_d         = raw & {N_CHAN{pwm_on}};
  end

  always_ff @(posedge clk_33) begin
    if (rst) begin
      div_cnt_q     <= '0;
      tick_ms_q     <= 1'b0;
      ms_cnt_q      <= '0;
      blink_phase_q <= 1'b0;
      pwm_cnt_q     <= '0;
      led_q         <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      tick_ms_q     <= tick_ms_d;
      ms_cnt_q      <= ms_cnt_d;
      blink_phase_q <= blink_phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
      led_q         <= led_d;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel stretch counter and mode mux
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
      logic [S_W-1:0] s_cnt_q, s_cnt_d;
      logic [1:0]     ch_mode;
      logic           raw_bit;

      assign ch_mode = mode[2*gi +: 2];

      // The counter runs regardless of mode so that switching into STRETCH
      // shows whatever on-time is still pending. A new event always reloads,
      // even on a tick cycle, so the full on-time is never shortened.
      always_comb begin
        s_cnt_d = s_cnt_q;
        if (event_in[gi]) begin
          s_cnt_d = S_LOAD;
        end else if (tick && (s_cnt_q != '0)) begin
          s_cnt_d = s_cnt_q - S_W'(1);
        end
      end

      always_ff @(posedge clk_33) begin
        if (rst) begin
          s_cnt_q <= '0;
        end else begin
          s_cnt_q <= s_cnt_d;
        end
      end

      always_comb begin
        raw_bit = 1'b0;
        case (ch_mode)
          MODE_OFF:     raw_bit = 1'b0;
          MODE_ON:      raw_bit = 1'b1;
          MODE_BLINK:   raw_bit = blink_phase_q;
          MODE_STRETCH: raw_bit = (s_cnt_q != '0);
          default:      raw_bit = 1'b0;
        endcase
      end

      assign raw[gi] = raw_bit;
    end
  endgenerate

  assign tick_ms = tick_ms_q;
  assign led     = led_q;

endmodule

// File: tb/tb_status_led_bank.sv
// ---------------------------------------------------------------------------
// tb_status_led_bank
//
// Directed bench for status_led_bank with N_CHAN=4, TICK_DIV=4,
// BLINK_HALF_MS=3, STRETCH_MS=2, PWM_BITS=2. The stimulus process pushes the
// hand-derived expected LED / tick_ms values for each cycle into a scoreboard
// queue tagged with an absolute cycle number; a separate monitor pops and
// compares on every falling edge.
//
// Cycle numbering: cycle k (k >= 1) after a reset is the k-th clock period in
// which rst is low; internal ticks fall in cycles 4, 8, 12, ...
// ---------------------------------------------------------------------------
module tb_status_led_bank;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int BH = 3;
  localparam int SM = 2;
  localparam int PB = 2;

  logic            clk_33 = 1'b0;
  logic            rst = 1'b1;
  logic [2*N-1:0]  mode = '0;
  logic [N-1:0]    event_in = '0;
  logic [PB-1:0]   brightness = 2'd3;
  logic            tick_ms;
  logic [N-1:0]    led;

  status_led_bank #(
    .N_CHAN(N), .TICK_DIV(TD), .BLINK_HALF_MS(BH), .STRETCH_MS(SM), .PWM_BITS(PB)
  ) dut (
    .clk_33     (clk_33),
    .rst        (rst),
    .mode       (mode),
    .event_in   (event_in),
    .brightness (brightness),
    .tick_ms    (tick_ms),
    .led        (led)
  );

  always #5 clk_33 = ~clk_33;

  // Absolute cycle label: number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk_33) cyc <= cyc + 1;

  typedef struct {
    int         c;
    int         k;
    logic [3:0] mask;
    logic [3:0] val;
    bit         chkt;
    bit         tv;
    int         tid;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   t0    = 0;

  function automatic string tname(input int id);
    case (id)
      0: return "in_reset";
      1: return "reset_idle";
      2: return "on_mode";
      3: return "blink";
      4: return "stretch";
      5: return "pwm";
      6: return "reset_midop";
      default: return "unknown";
    endcase
  endfunction

  function automatic int at(input int k);
    return t0 + k - 1;
  endfunction

  task automatic push(input int c, input int k, input logic [3:0] mask,
                      input logic [3:0] val, input bit chkt, input bit tv,
                      input int tid);
    exp_t e;
    int   i;
    e.c = c; e.k = k; e.mask = mask; e.val = val;
    e.chkt = chkt; e.tv = tv; e.tid = tid;
    i = q.size();
    while (i > 0 && q[i-1].c > c) i--;
    q.insert(i, e);
  endtask

  task automatic step();
    @(posedge clk_33);
    #1;
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  // Holds rst for n edges; every cycle after a reset edge must show led=0
  // and tick_ms=0. Leaves the bench in cycle 1 of the released design.
  task automatic do_reset(input int n);
    int c;
    c = cyc;
    rst = 1'b1;
    for (int i = 1; i <= n; i++) push(c + i, i - n, 4'hF, 4'h0, 1'b1, 1'b0, 0);
    repeat (n) step();
    rst = 1'b0;
    t0 = cyc;
  endtask

  // Monitor: compare everything due in the current cycle, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_33);
      while (q.size() > 0 && q[0].c <= cyc) begin
        e = q.pop_front();
        total++;
        if (e.c < cyc) begin
          bad++;
          $display("FAIL %s k=%0d check missed (due cyc=%0d, now=%0d)",
                   tname(e.tid), e.k, e.c, cyc);
        end else if (((led & e.mask) !== e.val) || (e.chkt && (tick_ms !== e.tv))) begin
          bad++;
          $display("FAIL %s k=%0d led=%b required=%b (mask %b) tick_ms=%b required=%b",
                   tname(e.tid), e.k, led & e.mask, e.val, e.mask, tick_ms,
                   e.chkt ? e.tv : tick_ms);
        end
      end
    end
  end

  initial begin
    logic ph, l2, l3, l1, l0;
    logic [PB-1:0] bprev;

    // 1. Reset / idle: no LEDs, tick_ms in cycles 5, 9, 13.
    mode = '0; brightness = 2'd3; event_in = '0;
    do_reset(3);
    for (int k = 1; k <= 16; k++) begin
      push(at(k), k, 4'hF, 4'h0, 1'b1, (k == 5 || k == 9 || k == 13), 1);
      step();
    end

    // 2. ON: ch0 switched on in cycle 3 -> led[0] from cycle 4.
    mode = '0; brightness = 2'd3;
    do_reset(2);
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) set_mode(0, 2'd1);
      push(at(k), k, 4'hF, {3'b000, (k >= 4) ? 1'b1 : 1'b0}, 1'b0, 1'b0, 2);
      step();
    end

    // 3. BLINK on ch1/ch2: phase high in cycles 14..25 and 38..49.
    //    ch2 forced ON in cycles 28..32, back to BLINK in 33; ch1 unaffected.
    mode = '0; brightness = 2'd3;
    set_mode(1, 2'd2); set_mode(2, 2'd2);
    do_reset(2);
    for (int k = 1; k <= 50; k++) begin
      if (k == 28) set_mode(2, 2'd1);
      if (k == 33) set_mode(2, 2'd2);
      ph = ((k >= 14 && k <= 25) || (k >= 38 && k <= 49));
      l2 = (k >= 29 && k <= 33) ? 1'b1 : ph;
      push(at(k), k, 4'hF, {1'b0, l2, ph, 1'b0}, 1'b0, 1'b0, 3);
      step();
    end

    // 4. STRETCH on ch3: events at 3 (tick next), 14 + retrigger 18,
    //    28 + reload on tick cycle 32. ch2 counts while OFF, then shows the
    //    remaining time once switched to STRETCH in cycle 34.
    mode = '0; brightness = 2'd3;
    set_mode(3, 2'd3);
    do_reset(2);
    for (int k = 1; k <= 44; k++) begin
      event_in = '0;
      if (k == 3 || k == 14 || k == 18 || k == 28 || k == 32) event_in[3] = 1'b1;
      if (k == 28) event_in[2] = 1'b1;
      if (k == 34) set_mode(2, 2'd3);
      l3 = ((k >= 5 && k <= 9) || (k >= 16 && k <= 25) || (k >= 30 && k <= 41));
      l2 = (k >= 35 && k <= 37);
      push(at(k), k, 4'hF, {l3, l2, 2'b00}, 1'b0, 1'b0, 4);
      step();
    end
    event_in = '0;

    // 5. PWM on ch0 (ON): led in cycle k reflects pwm_cnt=(k-2)%4 and the
    //    brightness of cycle k-1. Brightness 1, 2, 0, 3 for 8 cycles each.
    mode = '0; set_mode(0, 2'd1); brightness = 2'd1;
    do_reset(2);
    bprev = 2'd1;
    for (int k = 1; k <= 33; k++) begin
      if (k == 1)             l0 = 1'b0;
      else if (bprev == 2'd3) l0 = 1'b1;
      else                    l0 = (((k - 2) % 4) < int'(bprev));
      push(at(k), k, 4'hF, {3'b000, l0}, 1'b0, 1'b0, 5);
      if (k == 9)  brightness = 2'd2;
      if (k == 17) brightness = 2'd0;
      if (k == 25) brightness = 2'd3;
      bprev = brightness;
      step();
    end

    // 6. Reset mid-operation: ch1 blinking high, ch3 stretched (event 15,
    //    led high 17..21); rst asserted in cycle 18.
    mode = '0; brightness = 2'd3;
    set_mode(1, 2'd2); set_mode(3, 2'd3);
    do_reset(2);
    for (int k = 1; k <= 17; k++) begin
      event_in = '0;
      if (k == 15) event_in[3] = 1'b1;
      l1 = (k >= 14);
      l3 = (k >= 17);
      push(at(k), k, 4'hF, {l3, 1'b0, l1, 1'b0}, 1'b0, 1'b0, 6);
      step();
    end
    event_in = '0;
    push(at(18), 18, 4'hF, 4'b1010, 1'b0, 1'b0, 6);
    do_reset(2);
    for (int k = 1; k <= 20; k++) begin
      l1 = (k >= 14);
      push(at(k), k, 4'hF, {2'b00, l1, 1'b0}, 1'b0, 1'b0, 6);
      step();
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && q.size() > 0; i++) step();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
